// File: rtl/hyperbus_pkg.sv
// Shared encodings for the HyperBus responder: FSM states, operation codes
// and the latency counter width.
package hyperbus_pkg;

  // One-hot FSM states
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_WAIT = 3'b010,
    ST_RESP = 3'b100
  } state_t;

  // Latched request operation
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Latency counter width; covers the full LATENCY range 1..255
  localparam int unsigned LAT_CNT_W = 8;

endpackage

// File: rtl/hyperbus_responder_if.sv
// hbus_* request/response bundle between an initiator (master) and the
// responder endpoint (slave).
interface hyperbus_responder_if #(
  parameter int unsigned HBUS_ADDR_WIDTH = 32,
  parameter int unsigned HBUS_DATA_WIDTH = 16
);

  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i;
  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i;
  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o;
  logic                       hbus_rrq;
  logic                       hbus_wrq;
  logic                       hbus_ready;
  logic                       hbus_valid;
  logic                       hbus_busy;

  modport master (
    output hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq,
    input  hbus_dat_o, hbus_ready, hbus_valid, hbus_busy
  );

  modport slave (
    input  hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq,
    output hbus_dat_o, hbus_ready, hbus_valid, hbus_busy
  );

endinterface

// File: rtl/hyperbus_resp_ram.sv
// Single-port synchronous word RAM with registered read port. The read
// register only updates on enabled reads, so it holds the last read word.
module hyperbus_resp_ram #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Array write; contents are not reset
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read, held between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/hyperbus_responder.sv
// Target-side hbus_* endpoint: accepts single-word read/write requests,
// waits LATENCY cycles, then answers from an internal word RAM. Requests
// arriving while a transfer is in its wait phase are counted and dropped.
module hyperbus_responder
  import hyperbus_pkg::*;
#(
  parameter int unsigned HBUS_ADDR_WIDTH = 32,
  parameter int unsigned HBUS_DATA_WIDTH = 16,
  parameter int unsigned MEM_AW          = 10,
  parameter int unsigned LATENCY         = 4,
  parameter int unsigned CNT_WIDTH       = 8
) (
  input  logic                 hbus_clk,
  input  logic                 hbus_rst,
  hyperbus_responder_if.slave  bus,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY - 1);

  state_t                     state;
  op_t                        op;
  logic [LAT_CNT_W-1:0]       lat_cnt;
  logic [MEM_AW-1:0]          idx;
  logic [HBUS_DATA_WIDTH-1:0] wdata;
  logic                       ready_q;
  logic                       valid_q;
  logic                       busy_q;

  logic                       req_any;
  logic                       accept;
  logic                       drop;
  logic [MEM_AW-1:0]          req_idx;
  logic                       ram_en;
  logic                       ram_we;
  logic [HBUS_DATA_WIDTH-1:0] ram_rdata;
  logic                       unused_adr;

  // Request decode: acceptance, drop detection and RAM strobes
  always_comb begin
    req_any = bus.hbus_rrq | bus.hbus_wrq;
    accept  = req_any && ((state == ST_IDLE) || (state == ST_RESP));
    drop    = (req_any && (state == ST_WAIT)) ||
              (accept && bus.hbus_rrq && bus.hbus_wrq);
    req_idx = bus.hbus_adr_i[MEM_AW:1];
    // The RAM access happens on the edge that enters RESP
    ram_en  = (state == ST_WAIT) && (lat_cnt == '0);
    ram_we  = (op == OP_WRITE);
  end

  assign unused_adr = ^{bus.hbus_adr_i[HBUS_ADDR_WIDTH-1:MEM_AW+1], bus.hbus_adr_i[0]};

  // Request FSM with latency counter and registered response strobes
  always_ff @(posedge hbus_clk or negedge hbus_rst) begin
    if (!hbus_rst) begin
      state   <= ST_IDLE;
      op      <= OP_READ;
      lat_cnt <= '0;
      idx     <= '0;
      wdata   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      unique case (state)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            state   <= ST_WAIT;
            lat_cnt <= LAT_LOAD;
            op      <= bus.hbus_wrq ? OP_WRITE : OP_READ;
            idx     <= req_idx;
            wdata   <= bus.hbus_dat_i;
            busy_q  <= 1'b1;
          end else begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == '0) begin
            state   <= ST_RESP;
            ready_q <= (op == OP_WRITE);
            valid_q <= (op == OP_READ);
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of ignored requests
  always_ff @(posedge hbus_clk or negedge hbus_rst) begin
    if (!hbus_rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  hyperbus_resp_ram #(
    .AW (MEM_AW),
    .DW (HBUS_DATA_WIDTH)
  ) u_ram (
    .clk   (hbus_clk),
    .rst_n (hbus_rst),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (idx),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  assign bus.hbus_dat_o = ram_rdata;
  assign bus.hbus_ready = ready_q;
  assign bus.hbus_valid = valid_q;
  assign bus.hbus_busy  = busy_q;

endmodule

// File: tb/tb_hyperbus_responder.sv
// Scoreboard bench for hyperbus_responder. Two instances share one stimulus
// stream; the second uses a 2-bit drop counter to exercise saturation.
module tb_hyperbus_responder;

  localparam int LAT   = 4;
  localparam int WORDS = 1024;

  typedef struct {
    bit          wr;
    int          idx;
    logic [15:0] wd;
    int          resp_edge;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rrq = 1'b0;
  logic        wrq = 1'b0;
  logic [31:0] adr = '0;
  logic [15:0] dat = '0;
  logic [7:0]  drop1;
  logic [1:0]  drop2;

  int edge_cnt  = 0;
  int last_acc  = -100;
  int last_resp = -100;
  int drops     = 0;
  int n_chk     = 0;
  int n_fail    = 0;

  item_t       sb[$];
  logic [15:0] mem_m [0:WORDS-1];
  logic [15:0] dat_exp = '0;

  hyperbus_responder_if #(.HBUS_ADDR_WIDTH(32), .HBUS_DATA_WIDTH(16)) bus1 ();
  hyperbus_responder_if #(.HBUS_ADDR_WIDTH(32), .HBUS_DATA_WIDTH(16)) bus2 ();

  assign bus1.hbus_adr_i = adr;
  assign bus1.hbus_dat_i = dat;
  assign bus1.hbus_rrq   = rrq;
  assign bus1.hbus_wrq   = wrq;
  assign bus2.hbus_adr_i = adr;
  assign bus2.hbus_dat_i = dat;
  assign bus2.hbus_rrq   = rrq;
  assign bus2.hbus_wrq   = wrq;

  hyperbus_responder #(
    .HBUS_ADDR_WIDTH (32),
    .HBUS_DATA_WIDTH (16),
    .MEM_AW          (10),
    .LATENCY         (LAT),
    .CNT_WIDTH       (8)
  ) dut (
    .hbus_clk (clk),
    .hbus_rst (rst),
    .bus      (bus1.slave),
    .drop_cnt (drop1)
  );

  hyperbus_responder #(
    .HBUS_ADDR_WIDTH (32),
    .HBUS_DATA_WIDTH (16),
    .MEM_AW          (10),
    .LATENCY         (LAT),
    .CNT_WIDTH       (2)
  ) dut2 (
    .hbus_clk (clk),
    .hbus_rst (rst),
    .bus      (bus2.slave),
    .drop_cnt (drop2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int sat(int n, int m);
    return (n > m) ? m : n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_cnt);
    end
  endtask

  // Monitor: pop the response due at this edge and compare every output
  always @(negedge clk) begin
    bit    exp_r;
    bit    exp_v;
    item_t it;
    bit    busy_exp;
    exp_r = 1'b0;
    exp_v = 1'b0;
    if (rst) begin
      if (sb.size() > 0 && sb[0].resp_edge == edge_cnt) begin
        it = sb.pop_front();
        if (it.wr) begin
          exp_r = 1'b1;
          mem_m[it.idx] = it.wd;
        end else begin
          exp_v = 1'b1;
          dat_exp = mem_m[it.idx];
        end
      end
      busy_exp = (edge_cnt >= last_acc) && (edge_cnt <= last_resp);
      chk("ready",       32'(bus1.hbus_ready), 32'(exp_r));
      chk("valid",       32'(bus1.hbus_valid), 32'(exp_v));
      chk("dat_o",       32'(bus1.hbus_dat_o), 32'(dat_exp));
      chk("busy",        32'(bus1.hbus_busy),  32'(busy_exp));
      chk("drop_cnt",    32'(drop1),           32'(sat(drops, 255)));
      chk("ready_w2",    32'(bus2.hbus_ready), 32'(exp_r));
      chk("valid_w2",    32'(bus2.hbus_valid), 32'(exp_v));
      chk("busy_w2",     32'(bus2.hbus_busy),  32'(busy_exp));
      chk("drop_cnt_w2", 32'(drop2),           32'(sat(drops, 3)));
    end
  end

  // Present one request cycle and update the reference model for that edge
  task automatic issue(bit r, bit w, logic [31:0] a, logic [15:0] d);
    int e;
    item_t it;
    @(negedge clk);
    rrq = r;
    wrq = w;
    adr = a;
    dat = d;
    @(posedge clk);
    #1;
    e = edge_cnt;
    if (r || w) begin
      if (e > last_resp) begin
        last_acc  = e;
        last_resp = e + LAT;
        it.wr        = w;
        it.idx       = int'((a >> 1) % WORDS);
        it.wd        = d;
        it.resp_edge = e + LAT;
        sb.push_back(it);
        if (r && w) drops++;
      end else begin
        drops++;
      end
    end
    rrq = 1'b0;
    wrq = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Asynchronous reset mid-cycle; responses whose edge already passed stand
  task automatic do_reset();
    item_t it;
    rst = 1'b0;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      if (it.wr && it.resp_edge <= edge_cnt) mem_m[it.idx] = it.wd;
    end
    last_acc  = -100;
    last_resp = -100;
    drops     = 0;
    dat_exp   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(10);

    // Fill every word back-to-back so all later reads have known data
    for (int i = 0; i < WORDS; i++) begin
      issue(1'b0, 1'b1, 32'(i * 2), 16'($urandom));
      idle(LAT);
    end
    idle(2);

    // Write then read the same word; data must hold afterwards
    issue(1'b0, 1'b1, 32'h0000_0004, 16'hBEEF);
    idle(LAT);
    issue(1'b1, 1'b0, 32'h0000_0004, 16'h0000);
    idle(LAT + 10);

    // Address wrap modulo RAM size
    issue(1'b0, 1'b1, 32'h0000_0802, 16'h1234);
    idle(LAT + 2);
    issue(1'b1, 1'b0, 32'h0000_0002, 16'h0000);
    idle(LAT + 2);

    // Back-to-back: write accepted in the RESP cycle of a read
    issue(1'b1, 1'b0, 32'h0000_0100, 16'h0000);
    idle(LAT);
    issue(1'b0, 1'b1, 32'h0000_0100, 16'hA5A5);
    idle(LAT);
    issue(1'b1, 1'b0, 32'h0000_0100, 16'h0000);
    idle(LAT + 2);

    // Drops in WAIT, then simultaneous read+write at accept
    issue(1'b0, 1'b1, 32'h0000_0040, 16'h5555);
    for (int i = 0; i < 3; i++) issue(1'b1, 1'b0, 32'h0000_0042, 16'h0000);
    idle(1);
    issue(1'b1, 1'b1, 32'h0000_0044, 16'h7777);
    issue(1'b1, 1'b0, 32'h0000_0046, 16'h0000);
    idle(LAT + 2);
    issue(1'b1, 1'b0, 32'h0000_0044, 16'h0000);
    idle(LAT + 2);

    // Abort a write with reset mid-WAIT; old data must survive
    issue(1'b0, 1'b1, 32'h0000_0010, 16'hDEAD);
    idle(2);
    do_reset();
    idle(3);
    issue(1'b1, 1'b0, 32'h0000_0010, 16'h0000);
    idle(LAT + 2);

    // Randomized traffic with random gaps and occasional reset
    for (int i = 0; i < 400; i++) begin
      bit r;
      bit w;
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      issue(r, w, $urandom, 16'($urandom));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, LAT + 1)));
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    idle(LAT + 3);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hyperbus_responder.md
Name: hyperbus_responder

Overview:
Target-side endpoint of the hbus_* request/response interface. It sits where the HyperBus PHY/controller normally sits, so it is the other end from the FIFO/Wishbone bridge: it accepts single-word read/write requests, applies a programmable access latency, and answers with hbus_ready/hbus_valid/hbus_busy from an internal word RAM. It is used for loopback bring-up of the Wishbone bridge without a physical HyperRAM, and for latency stress testing.

Parameters:
HBUS_ADDR_WIDTH, 32, width of the byte address from the initiator
HBUS_DATA_WIDTH, 16, word width
MEM_AW, 10, log2 of the RAM depth in words (1024 words)
LATENCY, 4, wait cycles between request accept and response; legal range 1..255
CNT_WIDTH, 8, width of the dropped-request counter

Ports:
hbus_clk  in  1  clock
hbus_rst  in  1  asynchronous, active-low reset
hbus_adr_i  in  HBUS_ADDR_WIDTH  byte address; sampled with rrq/wrq
hbus_dat_i  in  HBUS_DATA_WIDTH  write data; sampled with wrq
hbus_dat_o  out  HBUS_DATA_WIDTH  read data; valid when hbus_valid=1
hbus_rrq  in  1  read request, one-cycle pulse
hbus_wrq  in  1  write request, one-cycle pulse
hbus_ready  out  1  one-cycle pulse: write committed
hbus_valid  out  1  one-cycle pulse: hbus_dat_o holds read data
hbus_busy  out  1  high while a request is outstanding
drop_cnt  out  CNT_WIDTH  count of requests ignored while busy; saturating

Behaviour:
- Reset (hbus_rst=0, asynchronous): state IDLE. hbus_ready, hbus_valid and hbus_busy are 0. hbus_dat_o is 0. drop_cnt is 0. The latency counter and request registers are cleared. RAM contents are not reset (undefined).
- Reset mid-operation aborts the transaction. A pending write whose response edge has not occurred is not committed.
- Word index is hbus_adr_i[MEM_AW:1]. Bit 0 and bits above MEM_AW are ignored, so addresses wrap modulo the RAM size.
- A request is accepted on an edge where (hbus_rrq | hbus_wrq) is high and the state is IDLE or RESP. Acceptance registers the operation, word index and write data.
- If hbus_rrq and hbus_wrq are both high: the write is accepted, the read is discarded, and drop_cnt increments by 1.
- FSM states are IDLE, WAIT and RESP:
  - IDLE → WAIT on accept; the counter loads LATENCY-1.
  - WAIT: the counter decrements each edge. When the counter is 0, go to RESP.
  - RESP lasts exactly one cycle:
    - Write: the RAM is written at the edge entering RESP, and hbus_ready=1 during RESP.
    - Read: the RAM is read at the edge entering RESP, hbus_dat_o is loaded, and hbus_valid=1 during RESP.
  - RESP → WAIT if a new request is accepted on that edge (back-to-back), else RESP → IDLE.
- Latency: a request accepted at edge k gives a response pulse in the cycle after edge k+LATENCY.
- hbus_busy=1 in WAIT and RESP, and 0 in IDLE.
- hbus_dat_o holds its value until the next read response. It is unchanged by writes.
- Read-after-write to the same word returns the new data, because the write commits before any later read response.
- A request seen in WAIT is ignored and drop_cnt increments. drop_cnt saturates at all-ones.
- hbus_ready and hbus_valid are never high together. Each is high for at most one cycle per accepted request.

Decomposition:
- Shared package hyperbus_pkg holds:
  - the state encodings (one-hot, 3 bits);
  - the op encoding (OP_READ, OP_WRITE).
- One sub-module: hyperbus_resp_ram. It is a single-port synchronous RAM of 2^MEM_AW × HBUS_DATA_WIDTH with write enable and registered read, so it infers as block RAM.
- The FSM, latency counter and drop counter stay in the top module.

Test Plan:
- Reset, then idle for 10 cycles → all outputs 0 and hbus_busy=0. Assert reset mid-WAIT of a write to 0x10 → no ready pulse; a later read of 0x10 does not return the aborted data.
- Write 0xBEEF to address 0x0004 at edge k (LATENCY=4) → hbus_busy=1 from k+1; hbus_ready=1 only in the cycle after k+4; hbus_busy=0 after k+5.
- Read 0x0004 after that write → hbus_valid pulses 4 cycles after accept with hbus_dat_o=0xBEEF; hbus_dat_o still 0xBEEF 10 cycles later.
- Wrap: write 0x1234 to 0x0802 (MEM_AW=10), read 0x0002 → 0x1234.
- Back-to-back: issue a write during the RESP cycle of a previous read → accepted; hbus_busy stays 1 continuously; drop_cnt=0.
- Drops: pulse rrq in WAIT three times, then assert rrq and wrq together once → drop_cnt=4, only the write completes. With CNT_WIDTH=2, 5 drops → drop_cnt=3.
